// File: rtl/renode_ahb_subordinate_mem.sv
// AHB-Lite subordinate that turns each accepted NONSEQ/SEQ beat into one
// request/response transaction on a simple memory backend. Wait states are
// inserted until the backend answers; bad decodes and backend errors get the
// two-cycle ERROR response.
//
// Backend handshake: a request transfers on a cycle where mem_req_valid and
// mem_req_ready are both high; mem_req_valid, mem_req_addr and mem_req_write
// hold steady until then. mem_rsp_valid is a one-cycle pulse that is only
// consumed after the request has transferred; pulses at any other time are
// ignored.
module renode_ahb_subordinate_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    SIZE_BYTES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [3:0]            HBURST,
  input  logic                  HWRITE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  input  logic                  mem_rsp_error,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RSP  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR1 = 3'd4,
    ST_ERR2 = 3'd5
  } state_e;

  localparam int                    BYTES      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  // Window bounds carry one extra bit so a window ending at the top of the
  // address space does not wrap.
  localparam logic [ADDR_WIDTH:0]   WIN_LO     = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0]   WIN_HI     = WIN_LO + (ADDR_WIDTH+1)'(SIZE_BYTES);

  state_e                  state_q;
  logic                    hreadyout_q;
  logic                    hresp_q;
  logic [DATA_WIDTH-1:0]   hrdata_q;
  logic                    req_valid_q;
  logic                    req_write_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [DATA_WIDTH-1:0]   req_wdata_q;

  logic                    accept;
  logic                    bad;
  logic [ADDR_WIDTH:0]     haddr_ext;
  logic [ADDR_WIDTH-1:0]   offset_d;

  // Burst type and the NONSEQ/SEQ distinction do not change how a beat is served.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  // Address-phase qualification and decode of the presented address.
  always_comb begin
    haddr_ext = {1'b0, HADDR};
    accept    = HSEL & HREADY & HTRANS[1];
    bad       = (haddr_ext < WIN_LO) || (haddr_ext >= WIN_HI) ||
                ((HADDR & ALIGN_MASK) != '0);
    offset_d  = HADDR - BASE_ADDR;
  end

  // Transfer FSM; all bus and backend outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          if (accept && bad) begin
            state_q     <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
            req_valid_q <= 1'b0;
          end else if (accept) begin
            state_q     <= ST_REQ;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b0;
            req_valid_q <= 1'b1;
            req_write_q <= HWRITE;
            req_addr_q  <= offset_d;
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            req_valid_q <= 1'b0;
          end
        end
        ST_REQ: begin
          // Write data arrives in the data phase; keep the last value seen.
          req_wdata_q <= HWDATA;
          if (mem_req_ready) begin
            state_q     <= ST_RSP;
            req_valid_q <= 1'b0;
          end
        end
        ST_RSP: begin
          if (mem_rsp_valid && mem_rsp_error) begin
            state_q     <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else if (mem_rsp_valid) begin
            state_q     <= ST_DONE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            if (!req_write_q) begin
              hrdata_q <= mem_rsp_rdata;
            end
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign HREADYOUT     = hreadyout_q;
  assign HRESP         = hresp_q;
  assign HRDATA        = hrdata_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_write = req_write_q;
  assign mem_req_addr  = req_addr_q;
  // While the request is pending the backend sees HWDATA directly.
  assign mem_req_wdata = (state_q == ST_REQ) ? HWDATA : req_wdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_renode_ahb_subordinate_mem.sv
// Bench for renode_ahb_subordinate_mem: single-manager AHB bus plus a scripted
// backend. The model predicts every data phase from its wait-state count and
// response kind, and a memory array supplies read data.
module tb_renode_ahb_subordinate_mem;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          SIZE  = 4096;
  localparam int          WORDS = SIZE / 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [3:0]    HBURST;
  logic          HWRITE;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [DW-1:0] HRDATA;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;
  logic          mem_rsp_error;
  logic [2:0]    unused_dbg_state;

  always #5 clk = ~clk;

  // Only subordinate on the bus, so bus HREADY is its own HREADYOUT.
  assign HREADY = HREADYOUT;

  renode_ahb_subordinate_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .SIZE_BYTES(SIZE)
  ) dut (
    .clk(clk), .rst(rst),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_error(mem_rsp_error),
    .dbg_state_o(unused_dbg_state)
  );

  // ---------------- transfer list and model state ----------------
  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          rd;     // cycles mem_req_ready stays low
    int          sd;     // extra cycles before the response pulse
    bit          berr;   // backend answers with an error
    int          rst_k;  // data-phase cycle at which reset is pulsed, -1 none
  } item_t;

  item_t       items[$];
  logic [31:0] mem [WORDS];
  logic [31:0] exp_q[$];   // expected backend request offsets, in order

  int errors = 0;
  int checks = 0;

  bit          dp_v;
  item_t       dp;
  int          dp_k;
  int          dp_waits;
  bit          dp_bad;
  bit          dp_err_resp;
  logic [31:0] exp_hrdata;
  bit          hrdata_known;
  bit          pristine;
  int          ghost;

  int          waits_log[$];
  int          valid_log[$];
  logic [31:0] resp_log[$];
  logic [31:0] rdata_log[$];
  logic [31:0] hs_log[$];
  int          cur_waits;
  int          cur_valid;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic item_t mk(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                               input logic w, input logic [31:0] d, input int rd,
                               input int sd, input bit be);
    item_t it;
    it.sel = sel; it.trans = tr; it.addr = a; it.write = w; it.wdata = d;
    it.rd = rd; it.sd = sd; it.berr = be; it.rst_k = -1;
    return it;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = BASE + 32'(4 * $urandom_range(0, WORDS-1)) + 32'($urandom_range(1, 3));
      1:       a = 32'($urandom_range(0, int'(BASE) - 1));
      2:       a = BASE + 32'(SIZE) + 32'(4 * $urandom_range(0, 255));
      default: a = BASE + 32'(4 * $urandom_range(0, WORDS-1));
    endcase
    return a;
  endfunction

  // ---------------- one bus cycle: check, drive, advance ----------------
  task automatic step();
    logic  exp_rdy, exp_resp, exp_val, rst_now, take;
    int    idx;
    item_t it;
    exp_rdy = 1'b1; exp_resp = 1'b0; exp_val = 1'b0; idx = 0;
    if (dp_v) begin
      if (!dp_bad) idx = int'((dp.addr - BASE) >> 2);
      exp_rdy  = (dp_k == dp_waits);
      exp_resp = dp_err_resp && (dp_k >= dp_waits - 1);
      exp_val  = !dp_bad && (dp_k <= dp.rd);
      if (dp_k == dp_waits) begin
        if (dp_err_resp) hrdata_known = 0;
        else if (!dp.write) begin exp_hrdata = mem[idx]; hrdata_known = 1; end
        else mem[idx] = dp.wdata;
      end
    end

    check("hreadyout", 32'(HREADYOUT), 32'(exp_rdy));
    check("hresp", 32'(HRESP), 32'(exp_resp));
    check("req_valid", 32'(mem_req_valid), 32'(exp_val));
    if (hrdata_known) check("hrdata", HRDATA, exp_hrdata);
    if (exp_val) begin
      check("req_addr", mem_req_addr, dp.addr - BASE);
      check("req_write", 32'(mem_req_write), 32'(dp.write));
      if (dp.write) check("req_wdata", mem_req_wdata, dp.wdata);
    end
    if (pristine) begin
      check("rst_req_addr", mem_req_addr, 32'h0);
      check("rst_req_write", 32'(mem_req_write), 32'h0);
      check("rst_req_wdata", mem_req_wdata, 32'h0);
    end

    if (dp_v) begin
      if (!HREADYOUT) cur_waits++;
      if (mem_req_valid) cur_valid++;
      if (dp_k == dp_waits) begin
        waits_log.push_back(cur_waits);
        valid_log.push_back(cur_valid);
        resp_log.push_back(32'(HRESP));
        rdata_log.push_back(HRDATA);
      end
    end

    // backend
    rst = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_error = 1'b0;
    mem_rsp_rdata = $urandom;
    HBURST = 4'($urandom_range(0, 7));
    if (ghost > 0) begin
      mem_rsp_valid = 1'b1; mem_rsp_error = 1'($urandom_range(0, 1));
      ghost--;
    end
    if (dp_v && !dp_bad) begin
      if (dp_k == dp.rd) mem_req_ready = 1'b1;
      if (dp_k <= dp.rd && $urandom_range(0, 3) == 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_error = 1'($urandom_range(0, 1));
      end
      if (dp_k == dp.rd + 1 + dp.sd) begin
        mem_rsp_valid = 1'b1; mem_rsp_error = dp.berr;
        if (!dp.write) mem_rsp_rdata = mem[idx];
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      hs_log.push_back(mem_req_addr);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL hs_unexpected: got request %h expected none", mem_req_addr);
      end else begin
        check("hs_addr", mem_req_addr, exp_q.pop_front());
      end
    end

    // manager address phase
    rst_now = dp_v && (dp.rst_k >= 0) && (dp_k == dp.rst_k);
    if (rst_now) rst = 1'b1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    take = 1'b0;
    if (items.size() > 0 && !rst_now) begin
      HSEL = items[0].sel; HTRANS = items[0].trans;
      HADDR = items[0].addr; HWRITE = items[0].write;
      take = !dp_v || (dp_k == dp_waits);
    end

    // advance model
    if (rst_now) begin
      dp_v = 0; ghost = 2; exp_hrdata = 32'h0; hrdata_known = 1; pristine = 1;
      exp_q.delete();
    end else begin
      if (dp_v) begin
        if (dp_k == dp_waits) dp_v = 0;
        else dp_k++;
      end
      if (take) begin
        it = items.pop_front();
        if (it.sel && it.trans[1]) begin
          pristine    = 0;
          dp          = it;
          dp_v        = 1;
          dp_k        = 0;
          cur_waits   = 0;
          cur_valid   = 0;
          dp_bad      = (it.addr < BASE) || (it.addr >= BASE + 32'(SIZE)) || (it.addr[1:0] != 2'b00);
          dp_err_resp = dp_bad || it.berr;
          dp_waits    = dp_bad ? 1 : 2 + it.rd + it.sd + (it.berr ? 1 : 0);
          if (!dp_bad) exp_q.push_back(it.addr - BASE);
          HWDATA = it.wdata;
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] exp_hs [8];
    int          exp_w  [10];
    int          exp_v  [10];
    logic [31:0] exp_r  [10];
    item_t       it;
    int          guard;

    rst = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HBURST = 4'h0;
    HWRITE = 1'b0; HWDATA = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0; mem_rsp_error = 1'b0;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[1] = 32'hDEAD_BEEF;
    dp_v = 0; pristine = 1; hrdata_known = 1; exp_hrdata = 32'h0; ghost = 0;
    cur_waits = 0; cur_valid = 0;

    // directed transfers (indices pinned by the literal checks below)
    items.push_back(mk(1, 2'b10, 32'h1004, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b10, 32'h1008, 1, 32'h1234_5678, 3, 0, 0));
    items.push_back(mk(1, 2'b10, 32'h2000, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b10, 32'h1002, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b10, 32'h1010, 1, $urandom, 0, 0, 1));
    items.push_back(mk(1, 2'b10, 32'h1014, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b10, 32'h1000, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b11, 32'h1004, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b01, 32'h1008, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b11, 32'h1008, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b11, 32'h100C, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b00, 32'h0000, 0, $urandom, 0, 0, 0));
    // window edges
    items.push_back(mk(1, 2'b10, 32'h1FFC, 1, $urandom, 1, 1, 0));
    items.push_back(mk(1, 2'b10, 32'h1FFC, 0, $urandom, 0, 2, 0));
    items.push_back(mk(1, 2'b10, 32'h0FFC, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b10, 32'hFFFF_FFFC, 0, $urandom, 0, 0, 0));
    items.push_back(mk(0, 2'b10, 32'h1004, 0, $urandom, 0, 0, 0));

    // random traffic
    for (int i = 0; i < 250; i++) begin
      logic [1:0] tr;
      case ($urandom_range(0, 19))
        0, 1, 2:    tr = 2'b00;
        3, 4, 5:    tr = 2'b01;
        6, 7, 8, 9, 10, 11: tr = 2'b11;
        default:    tr = 2'b10;
      endcase
      items.push_back(mk(1'($urandom_range(0, 9) != 0), tr, rand_addr(),
                         1'($urandom_range(0, 1)), $urandom,
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 7) == 0));
    end

    // reset while waiting for the response, then recovery traffic
    it = mk(1, 2'b10, 32'h1020, 0, $urandom, 1, 6, 0);
    it.rst_k = 3;
    items.push_back(it);
    items.push_back(mk(1, 2'b00, 32'h0, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b00, 32'h0, 0, $urandom, 0, 0, 0));
    items.push_back(mk(1, 2'b10, 32'h1004, 0, $urandom, 0, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    guard = 0;
    while ((items.size() > 0 || dp_v) && guard < 20000) begin
      step();
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d cycles expected fewer than 20000", guard);
    end
    repeat (3) begin
      step();
      @(negedge clk);
    end

    // literal expectations for the directed transfers
    exp_hs = '{32'h4, 32'h8, 32'h10, 32'h14, 32'h0, 32'h4, 32'h8, 32'hC};
    exp_w  = '{2, 5, 1, 1, 3, 2, 2, 2, 2, 2};
    exp_v  = '{1, 4, 0, 0, 1, 1, 1, 1, 1, 1};
    exp_r  = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    if (hs_log.size() < 8 || waits_log.size() < 10) begin
      checks++; errors++;
      $display("FAIL log_size: got %0d/%0d expected at least 8/10", hs_log.size(), waits_log.size());
    end else begin
      for (int i = 0; i < 8; i++) check("lit_hs_addr", hs_log[i], exp_hs[i]);
      for (int i = 0; i < 10; i++) begin
        check("lit_waits", 32'(waits_log[i]), 32'(exp_w[i]));
        check("lit_valid_cycles", 32'(valid_log[i]), 32'(exp_v[i]));
        check("lit_resp", resp_log[i], exp_r[i]);
      end
      check("lit_read_data", rdata_log[0], 32'hDEAD_BEEF);
    end
    check("leftover_requests", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/renode_ahb_subordinate_mem.md
Name: renode_ahb_subordinate_mem

Overview:
AHB-Lite subordinate (responder) endpoint for the Renode AHB integration. It accepts manager transfers and converts each accepted beat into a single request/response transaction on a simple memory backend. It inserts wait states until the backend answers and generates the two-cycle AHB ERROR response. It sits between an AHB interconnect slot (`ahb_subordinate_t` signals) and a Renode-driven or RTL memory model.

Parameters:
ADDR_WIDTH, 32, HADDR and backend address width
DATA_WIDTH, 32, HWDATA/HRDATA and backend data width; transfers are always full-width
BASE_ADDR, 32'h0000_0000, first byte address decoded by this subordinate
SIZE_BYTES, 4096, decoded window size in bytes; must be a power of two, at least DATA_WIDTH/8

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
HSEL  in  1  subordinate select
HADDR  in  ADDR_WIDTH  transfer address
HTRANS  in  2  ahb_trans_e (IDLE/BUSY/NONSEQ/SEQ)
HBURST  in  4  ahb_burst_e; informational only
HWRITE  in  1  1 = write
HWDATA  in  DATA_WIDTH  write data, valid in the data phase
HREADY  in  1  bus-level ready (previous transfer complete)
HREADYOUT  out  1  this subordinate's ready
HRESP  out  1  ahb_resp_e (OKAY=0, ERROR=1)
HRDATA  out  DATA_WIDTH  read data
mem_req_valid  out  1  backend request valid
mem_req_ready  in  1  backend accepts request
mem_req_write  out  1  request is a write
mem_req_addr  out  ADDR_WIDTH  byte offset from BASE_ADDR
mem_req_wdata  out  DATA_WIDTH  write data
mem_rsp_valid  in  1  backend response (one cycle pulse)
mem_rsp_rdata  in  DATA_WIDTH  read data with response
mem_rsp_error  in  1  backend error with response

Behaviour:
- Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_wdata=0. State is IDLE.
- Reset in any state aborts the transfer. A mem_rsp_valid arriving after reset is ignored.
- Address phase is accepted when HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ). At that point HADDR and HWRITE are registered.
- IDLE/BUSY transfers, or HSEL=0, get a zero-wait OKAY and no backend activity.
- Decode: the transfer is bad if HADDR < BASE_ADDR, or HADDR >= BASE_ADDR+SIZE_BYTES, or HADDR is not aligned to DATA_WIDTH/8. A bad transfer goes to ERR1 and never raises mem_req_valid.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=OKAY. A good accepted transfer goes to REQ; a bad one goes to ERR1.
  - REQ: HREADYOUT=0. mem_req_valid=1 with stable addr/write; mem_req_wdata follows HWDATA. mem_req_valid holds until mem_req_ready=1, then go to RSP. mem_rsp_valid in REQ is ignored.
  - RSP: HREADYOUT=0. On mem_rsp_valid:
    - mem_rsp_error=1 -> ERR1.
    - otherwise -> DONE. For reads, HRDATA is loaded from mem_rsp_rdata; for writes, HRDATA is left unchanged.
  - DONE: HREADYOUT=1, HRESP=OKAY, data phase completes. A new address phase may be accepted here (pipelined): good -> REQ, bad -> ERR1, none -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR. Always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Address-phase acceptance is the same as in DONE. A manager cancelling the burst (HTRANS=IDLE) -> IDLE.
- Minimum latency: address phase at cycle N; REQ at N+1 with ready=1; rsp_valid at N+2; DONE (HREADYOUT=1) at N+3. This is 2 wait states.
- HREADYOUT is registered (a function of state only). HRESP is ERROR only in ERR1/ERR2.
- SEQ beats of any HBURST are handled as independent transfers. BUSY inside a burst is a zero-wait OKAY with no backend access.
- mem_req_addr = HADDR - BASE_ADDR, truncated to ADDR_WIDTH.

Test Plan:
- Single read: BASE=0x1000, read 0x1004, ready=1, rsp next cycle with rdata 0xDEADBEEF -> one mem req (addr 0x4, write=0); HREADYOUT low 2 cycles; HRDATA=0xDEADBEEF with OKAY at N+3.
- Write with backpressure: write 0x1008 data 0x12345678, mem_req_ready low 3 cycles -> mem_req_valid held 4 cycles; addr 0x8 and wdata 0x12345678 stable; HREADYOUT low until the cycle after rsp; OKAY.
- Out-of-range and misaligned: reads at 0x2000 and 0x1002 -> no mem_req_valid; each gets HREADYOUT 0 then 1 with HRESP=ERROR for both cycles.
- Backend error: write 0x1010 answered with mem_rsp_error=1 -> ERR1/ERR2 sequence. A NONSEQ to 0x1014 presented in ERR2 is accepted and completes OKAY.
- INCR4 burst 0x1000..0x100C with one BUSY after beat 2 -> exactly 4 backend requests with addrs 0,4,8,C; BUSY gets a zero-wait OKAY; HRDATA matches each response.
- Reset in RSP: assert rst while awaiting a response; backend then pulses rsp_valid -> outputs at reset values; HREADYOUT=1; no spurious OKAY/ERROR or HRDATA change.
